// File: rtl/bram_wrapper_arbiter.sv
// Round-robin arbiter sharing one wide-word BRAM wrapper between NUM_REQ requesters.
// Optional watchdog (timeout_err_out port and counter) is built only when ARB_TIMEOUT_EN is defined.
module bram_wrapper_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDRS          = 1024,
    parameter int BRAM_WIDTH     = 64,
    parameter int PIECES         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int ADDR_SIZE     = $clog2(ADDRS),
    localparam int WIDTH         = PIECES * BRAM_WIDTH
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ-1:0]           req_write_in,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_in,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic [NUM_REQ-1:0]           resp_valid_out,
    output logic [WIDTH-1:0]             resp_data_out,
    output logic                         busy_out,
    output logic [ADDR_SIZE-1:0]         wr_addr_out,
    output logic [WIDTH-1:0]             wr_data_out,
    output logic                         wr_read_enable_out,
    output logic                         wr_write_enable_out,
    input  logic [WIDTH-1:0]             wr_data_in,
    input  logic                         wr_finished_in
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err_out
`endif
);

    // state  | meaning
    // IDLE   | waiting for any req_valid_in; grants and latches the command
    // ISSUE  | one-cycle read/write enable to the wrapper
    // SETTLE | one cycle where a stale finished flag is ignored
    // WAIT   | waiting for wr_finished_in (or the watchdog)
    // DONE   | one-cycle resp_valid_out pulse to the owner
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int OWN_W = $clog2(NUM_REQ);

    logic [2:0]           state;
    logic [OWN_W-1:0]     rr_q;
    logic [OWN_W-1:0]     owner_q;
    logic                 write_q;
    logic                 grant_found;
    logic [OWN_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic                 sel_write;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WIDTH-1:0]     sel_data;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;
`endif

    assign busy_out = (state != S_IDLE);

    // Search upward from rr+1: first requesters above rr, then wrap to those at or below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid_in[i] && (i > int'(rr_q))) begin
                grant_found = 1'b1;
                grant_idx   = OWN_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid_in[i] && (i <= int'(rr_q))) begin
                grant_found = 1'b1;
                grant_idx   = OWN_W'(i);
            end
        end
    end

    always_comb begin
        sel_write    = 1'b0;
        sel_addr     = '0;
        sel_data     = '0;
        grant_onehot = '0;
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = (OWN_W'(i) == grant_idx);
            owner_onehot[i] = (OWN_W'(i) == owner_q);
            if (OWN_W'(i) == grant_idx) begin
                sel_write = req_write_in[i];
                sel_addr  = req_addr_in[i*ADDR_SIZE +: ADDR_SIZE];
                sel_data  = req_data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= S_IDLE;
            rr_q                <= OWN_W'(NUM_REQ - 1);
            owner_q             <= '0;
            write_q             <= 1'b0;
            req_ready_out       <= '0;
            resp_valid_out      <= '0;
            resp_data_out       <= '0;
            wr_addr_out         <= '0;
            wr_data_out         <= '0;
            wr_read_enable_out  <= 1'b0;
            wr_write_enable_out <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timer_q             <= '0;
            timeout_err_out     <= 1'b0;
`endif
        end else begin
            req_ready_out       <= '0;
            resp_valid_out      <= '0;
            wr_read_enable_out  <= 1'b0;
            wr_write_enable_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_q             <= grant_idx;
                        rr_q                <= grant_idx;
                        write_q             <= sel_write;
                        wr_addr_out         <= sel_addr;
                        wr_data_out         <= sel_data;
                        req_ready_out       <= grant_onehot;
                        wr_write_enable_out <= sel_write;
                        wr_read_enable_out  <= !sel_write;
                        state               <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                    timer_q <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
`ifdef ARB_TIMEOUT_EN
                    timer_q <= timer_q - 1'b1;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wr_finished_in) begin
                        resp_valid_out <= owner_onehot;
                        if (!write_q) begin
                            resp_data_out <= wr_data_in;
                        end
                        state <= S_DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Terminal count reached: release the requester without fresh read data.
                    else if (timer_q == '0) begin
                        resp_valid_out  <= owner_onehot;
                        timeout_err_out <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_wrapper_arbiter.sv
// Bench for bram_wrapper_arbiter: behavioural wrapper model with adjustable latency plus a response scoreboard.
module tb_bram_wrapper_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int ADDRS          = 1024;
    localparam int BRAM_WIDTH     = 64;
    localparam int PIECES         = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ADDR_SIZE      = $clog2(ADDRS);
    localparam int WIDTH          = PIECES * BRAM_WIDTH;

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t PAT_A5 = {(WIDTH/8){8'hA5}};
    localparam word_t PAT_D0 = {(WIDTH/16){16'h3C5A}};
    localparam word_t PAT_D1 = {(WIDTH/32){32'hDEADBEEF}};

    typedef struct {
        int    owner;
        bit    is_write;
        word_t data;
    } exp_t;

    logic                         clk_in;
    logic                         rst_in;
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ-1:0]           req_write_in;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_in;
    logic [NUM_REQ*WIDTH-1:0]     req_data_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic [NUM_REQ-1:0]           resp_valid_out;
    word_t                        resp_data_out;
    logic                         busy_out;
    logic [ADDR_SIZE-1:0]         wr_addr_out;
    word_t                        wr_data_out;
    logic                         wr_read_enable_out;
    logic                         wr_write_enable_out;
    word_t                        wr_data_in;
    logic                         wr_finished_in;
`ifdef ARB_TIMEOUT_EN
    logic                         timeout_err_out;
`endif

    logic                 rv [NUM_REQ];
    logic                 rw [NUM_REQ];
    logic [ADDR_SIZE-1:0] ra [NUM_REQ];
    word_t                rd [NUM_REQ];

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  sb [$];
    int    grant_q [$];
    exp_t  e;
    logic [NUM_REQ-1:0] eo;

    // wrapper model
    word_t                mem [0:ADDRS-1];
    word_t                dout;
    logic                 fin;
    logic                 drop;
    int                   cnt;
    int                   lat;
    bit                   hang;
    logic [ADDR_SIZE-1:0] addr_q;

    bram_wrapper_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDRS(ADDRS),
        .BRAM_WIDTH(BRAM_WIDTH),
        .PIECES(PIECES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_valid_in(req_valid_in),
        .req_write_in(req_write_in),
        .req_addr_in(req_addr_in),
        .req_data_in(req_data_in),
        .req_ready_out(req_ready_out),
        .resp_valid_out(resp_valid_out),
        .resp_data_out(resp_data_out),
        .busy_out(busy_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .wr_read_enable_out(wr_read_enable_out),
        .wr_write_enable_out(wr_write_enable_out),
        .wr_data_in(wr_data_in),
        .wr_finished_in(wr_finished_in)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err_out(timeout_err_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always_comb begin
        req_valid_in = '0;
        req_write_in = '0;
        req_addr_in  = '0;
        req_data_in  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid_in[i]                          = rv[i];
            req_write_in[i]                          = rw[i];
            req_addr_in[i*ADDR_SIZE +: ADDR_SIZE]    = ra[i];
            req_data_in[i*WIDTH +: WIDTH]            = rd[i];
        end
    end

    // Finished stays high from the previous op until one cycle after the next enable.
    always @(posedge clk_in) begin
        if (rst_in) begin
            fin  <= 1'b0;
            drop <= 1'b0;
            cnt  <= 0;
        end else begin
            if (wr_write_enable_out || wr_read_enable_out) begin
                drop   <= 1'b1;
                cnt    <= lat;
                addr_q <= wr_addr_out;
                if (wr_write_enable_out) mem[wr_addr_out] <= wr_data_out;
            end
            if (drop) begin
                fin  <= 1'b0;
                drop <= 1'b0;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    fin  <= 1'b1;
                    dout <= mem[addr_q];
                end
            end
        end
    end

    assign wr_finished_in = fin & ~hang;
    assign wr_data_in     = hang ? '1 : dout;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_out[i]) grant_q.push_back(i);
            end
            if (resp_valid_out != '0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid_out=%b, nothing outstanding", resp_valid_out);
                end else begin
                    e = sb.pop_front();
                    eo = '0;
                    eo[e.owner] = 1'b1;
                    if (resp_valid_out !== eo) begin
                        n_fail++;
                        $display("FAIL resp_owner: got %b expected %b", resp_valid_out, eo);
                    end
                    if (!e.is_write) begin
                        n_checks++;
                        if (resp_data_out !== e.data) begin
                            n_fail++;
                            $display("FAIL resp_data: got ..%h expected ..%h", resp_data_out[63:0], e.data[63:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_cmd(input int i, input bit wr, input int addr, input word_t d,
                             output bit ok, output int cyc);
        rv[i] = 1'b1;
        rw[i] = wr;
        ra[i] = ADDR_SIZE'(addr);
        rd[i] = d;
        ok    = 1'b0;
        cyc   = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_in);
            cyc = c + 1;
            if (req_ready_out[i]) begin
                ok = 1'b1;
                break;
            end
        end
        rv[i] = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (sb.size() == 0 && !busy_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if ({req_ready_out, resp_valid_out, busy_out, wr_read_enable_out, wr_write_enable_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b resp=%b busy=%b re=%b we=%b expected all 0",
                     req_ready_out, resp_valid_out, busy_out, wr_read_enable_out, wr_write_enable_out);
        end
        n_checks++;
        if (wr_addr_out !== '0 || wr_data_out !== '0 || resp_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h data=..%h resp_data=..%h expected 0",
                     wr_addr_out, wr_data_out[63:0], resp_data_out[63:0]);
        end
`ifdef ARB_TIMEOUT_EN
        n_checks++;
        if (timeout_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout: got %b expected 0", timeout_err_out);
        end
`endif
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy_out);
        end
    endtask

    task automatic test_write();
        bit ok;
        int cyc;
        sb.push_back('{0, 1'b1, '0});
        drive_cmd(0, 1'b1, 5, PAT_A5, ok, cyc);
        n_checks++;
        if (!ok || cyc != 1) begin
            n_fail++;
            $display("FAIL write_ready: ok=%0d cycles=%0d expected ok=1 cycles=1", ok, cyc);
        end
        n_checks++;
        if (wr_write_enable_out !== 1'b1 || wr_read_enable_out !== 1'b0 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL write_issue: we=%b re=%b busy=%b expected 1 0 1",
                     wr_write_enable_out, wr_read_enable_out, busy_out);
        end
        n_checks++;
        if (wr_addr_out !== ADDR_SIZE'(5) || wr_data_out !== PAT_A5 || req_ready_out !== 2'b01) begin
            n_fail++;
            $display("FAIL write_bus: addr=%0d data=..%h ready=%b expected 5 ..a5 01",
                     wr_addr_out, wr_data_out[63:0], req_ready_out);
        end
        @(negedge clk_in);
        n_checks++;
        if (wr_write_enable_out !== 1'b0 || wr_read_enable_out !== 1'b0 || req_ready_out !== '0) begin
            n_fail++;
            $display("FAIL write_pulse_width: we=%b re=%b ready=%b expected 0 0 00",
                     wr_write_enable_out, wr_read_enable_out, req_ready_out);
        end
        n_checks++;
        if (wr_addr_out !== ADDR_SIZE'(5)) begin
            n_fail++;
            $display("FAIL write_addr_hold: got %0d expected 5", wr_addr_out);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_done: timed out, %0d responses outstanding", sb.size());
        end
    endtask

    task automatic test_read();
        bit ok;
        int cyc;
        sb.push_back('{0, 1'b0, PAT_A5});
        drive_cmd(0, 1'b0, 5, '0, ok, cyc);
        n_checks++;
        if (!ok || wr_read_enable_out !== 1'b1 || wr_write_enable_out !== 1'b0 || wr_addr_out !== ADDR_SIZE'(5)) begin
            n_fail++;
            $display("FAIL read_issue: ok=%0d re=%b we=%b addr=%0d expected 1 1 0 5",
                     ok, wr_read_enable_out, wr_write_enable_out, wr_addr_out);
        end
        wait_idle(ok);
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (!ok || resp_data_out !== PAT_A5) begin
            n_fail++;
            $display("FAIL read_hold: ok=%0d data=..%h expected ..a5", ok, resp_data_out[63:0]);
        end
    endtask

    task automatic test_stale_finished();
        bit ok;
        int cyc;
        int k;
        sb.push_back('{0, 1'b1, '0});
        drive_cmd(0, 1'b1, 12, PAT_D1, ok, cyc);
        wait_idle(ok);
        lat = 4;
        sb.push_back('{1, 1'b0, PAT_A5});
        drive_cmd(1, 1'b0, 5, '0, ok, cyc);
        k = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            k++;
            if (resp_valid_out != '0) break;
        end
        n_checks++;
        if (!ok || k != lat + 2) begin
            n_fail++;
            $display("FAIL stale_finished_latency: ok=%0d resp after %0d cycles expected %0d", ok, k, lat + 2);
        end
        wait_idle(ok);
        lat = 2;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        lat = 8;
        sb.push_back('{0, 1'b1, '0});
        drive_cmd(0, 1'b1, 20, PAT_D0, ok, cyc);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        sb.delete();
        n_checks++;
        if ({req_ready_out, resp_valid_out, busy_out, wr_read_enable_out, wr_write_enable_out} !== '0 ||
            wr_addr_out !== '0 || wr_data_out !== '0 || resp_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b resp=%b addr=%0d resp_data=..%h expected all 0",
                     busy_out, resp_valid_out, wr_addr_out, resp_data_out[63:0]);
        end
        rst_in = 1'b0;
        lat = 2;
        repeat (12) @(negedge clk_in);
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy=%b expected 0", busy_out);
        end
        sb.push_back('{1, 1'b0, PAT_A5});
        drive_cmd(1, 1'b0, 5, '0, ok, cyc);
        n_checks++;
        if (!ok || cyc != 1 || req_ready_out !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: ok=%0d cycles=%0d ready=%b expected 1 1 10", ok, cyc, req_ready_out);
        end
        wait_idle(ok);
    endtask

    task automatic test_round_robin();
        bit ok0a, ok0b, ok1a, ok1b, ok;
        int c0a, c0b, c1a, c1b;
        int exp_g [4] = '{0, 1, 0, 1};
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        grant_q.delete();
        sb.push_back('{0, 1'b1, '0});
        sb.push_back('{1, 1'b0, PAT_A5});
        sb.push_back('{0, 1'b0, PAT_D0});
        sb.push_back('{1, 1'b1, '0});
        fork
            begin
                drive_cmd(0, 1'b1, 10, PAT_D0, ok0a, c0a);
                drive_cmd(0, 1'b0, 10, '0, ok0b, c0b);
            end
            begin
                drive_cmd(1, 1'b0, 5, '0, ok1a, c1a);
                drive_cmd(1, 1'b1, 11, PAT_D1, ok1b, c1b);
            end
        join
        wait_idle(ok);
        n_checks++;
        if (!(ok0a && ok0b && ok1a && ok1b && ok) || grant_q.size() != 4) begin
            n_fail++;
            $display("FAIL rr_complete: grants=%0d expected 4, all ok=%0d", grant_q.size(),
                     ok0a && ok0b && ok1a && ok1b && ok);
        end else begin
            for (int g = 0; g < 4; g++) begin
                n_checks++;
                if (grant_q[g] != exp_g[g]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", g, grant_q[g], exp_g[g]);
                end
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cyc;
        int k;
        hang = 1'b1;
        n_checks++;
        if (timeout_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got %b expected 0", timeout_err_out);
        end
        sb.push_back('{0, 1'b0, PAT_D0});
        drive_cmd(0, 1'b0, 5, '0, ok, cyc);
        k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            k++;
            if (resp_valid_out != '0) break;
        end
        n_checks++;
        if (!ok || k != TIMEOUT_CYCLES + 1 || timeout_err_out !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_fire: ok=%0d resp after %0d cycles err=%b expected %0d and 1",
                     ok, k, timeout_err_out, TIMEOUT_CYCLES + 1);
        end
        hang = 1'b0;
        repeat (5) @(negedge clk_in);
        n_checks++;
        if (timeout_err_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b busy=%b expected 1 0", timeout_err_out, busy_out);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rv[i] = 1'b0;
            rw[i] = 1'b0;
            ra[i] = '0;
            rd[i] = '0;
        end
        rst_in = 1'b1;
        lat    = 2;
        hang   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stale_finished();
        test_reset_mid();
        test_round_robin();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_responses: %0d outstanding expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
